// File: rtl/player_record_pkg.sv
// player_record_pkg: record layout, store size and scan FSM encoding shared by the
// player record arbiter and its bench-facing top.
`default_nettype none

package player_record_pkg;

   localparam int NUM_PLAYERS = 5;
   localparam int RECORD_W    = 19;

   localparam int L2_UNLOCK_BIT = 18;
   localparam int L3_UNLOCK_BIT = 17;
   localparam int L2_TENS_LSB   = 13;
   localparam int L2_UNITS_LSB  = 9;
   localparam int L3_DONE_BIT   = 8;
   localparam int L3_TENS_LSB   = 4;
   localparam int L3_UNITS_LSB  = 0;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SCAN    = 2'd1,
      S_RESOLVE = 2'd2,
      S_DONE    = 2'd3
   } scan_state_t;

   // Combined L2+L3 score; fields are BCD so the sum never exceeds 198.
   function automatic logic [7:0] record_total(input logic [3:0] l2_tens,
                                               input logic [3:0] l2_units,
                                               input logic [3:0] l3_tens,
                                               input logic [3:0] l3_units);
      return {4'd0, l3_tens} * 8'd10 + {4'd0, l3_units}
           + {4'd0, l2_tens} * 8'd10 + {4'd0, l2_units};
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter3.sv
// rr_arbiter3: three-way round-robin arbiter; bit 0 = write, 1 = read, 2 = scan.
// The pointer names the highest-priority requester and moves past each grant.
`default_nettype none

module rr_arbiter3 (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] req,
   output logic [2:0] gnt
);

   logic [1:0] r_ptr;
   logic [1:0] w_next_ptr;

   always_comb begin
      gnt = 3'b000;
      case (r_ptr)
         2'd0: begin
            if      (req[0]) gnt = 3'b001;
            else if (req[1]) gnt = 3'b010;
            else if (req[2]) gnt = 3'b100;
         end
         2'd1: begin
            if      (req[1]) gnt = 3'b010;
            else if (req[2]) gnt = 3'b100;
            else if (req[0]) gnt = 3'b001;
         end
         default: begin
            if      (req[2]) gnt = 3'b100;
            else if (req[0]) gnt = 3'b001;
            else if (req[1]) gnt = 3'b010;
         end
      endcase
   end

   always_comb begin
      w_next_ptr = r_ptr;
      if      (gnt[0]) w_next_ptr = 2'd1;
      else if (gnt[1]) w_next_ptr = 2'd2;
      else if (gnt[2]) w_next_ptr = 2'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_ptr <= 2'd0;
      else     r_ptr <= w_next_ptr;
   end

endmodule

`default_nettype wire

// File: rtl/player_record_arbiter.sv
// player_record_arbiter: five player records shared by a masked write port, a read
// port and a high-score scan engine, one record access per cycle.
`default_nettype none

module player_record_arbiter
   import player_record_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_req,
   input  logic [2:0]          wr_id,
   input  logic [RECORD_W-1:0] wr_mask,
   input  logic [RECORD_W-1:0] wr_data,
   output logic                wr_gnt,
   input  logic                rd_req,
   input  logic [2:0]          rd_id,
   output logic                rd_gnt,
   output logic [RECORD_W-1:0] rd_data,
   input  logic                scan_start,
   output logic                scan_busy,
   output logic                scan_done,
   output logic [3:0]          winner_index,
   output logic [3:0]          winner_l2_tens,
   output logic [3:0]          winner_l2_units,
   output logic [3:0]          winner_l3_tens,
   output logic [3:0]          winner_l3_units
);

   localparam logic [2:0] c_ID_LIMIT = 3'(NUM_PLAYERS);
   localparam logic [2:0] c_LAST_IDX = 3'(NUM_PLAYERS - 1);

   logic [RECORD_W-1:0] r_store [NUM_PLAYERS];

   scan_state_t r_state;
   logic [2:0]  r_idx;
   logic [7:0]  r_best;
   logic [2:0]  r_best_idx;
   logic        r_unique;
   logic [15:0] r_best_scores;

   logic [2:0]  w_req;
   logic [2:0]  w_gnt;
   logic        w_wr_ok;
   logic        w_rd_ok;
   logic [15:0] w_scan_scores;
   logic [7:0]  w_scan_total;

   // A port whose grant pulse is showing sits out, so a request dropped on gnt
   // produces exactly one access.
   assign w_req = {r_state == S_SCAN, rd_req & ~rd_gnt, wr_req & ~wr_gnt};

   rr_arbiter3 u_rr (
      .clk (clk),
      .rst (rst),
      .req (w_req),
      .gnt (w_gnt)
   );

   assign w_wr_ok = (wr_id < c_ID_LIMIT);
   assign w_rd_ok = (rd_id < c_ID_LIMIT);

   assign w_scan_scores = {r_store[r_idx][L2_TENS_LSB +: 4], r_store[r_idx][L2_UNITS_LSB +: 4],
                           r_store[r_idx][L3_TENS_LSB +: 4], r_store[r_idx][L3_UNITS_LSB +: 4]};
   assign w_scan_total  = record_total(w_scan_scores[15:12], w_scan_scores[11:8],
                                       w_scan_scores[7:4],   w_scan_scores[3:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_PLAYERS; i++) r_store[i] <= '0;
      end else if (w_gnt[0] && w_wr_ok) begin
         r_store[wr_id] <= (r_store[wr_id] & ~wr_mask) | (wr_data & wr_mask);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_gnt  <= 1'b0;
         rd_gnt  <= 1'b0;
         rd_data <= '0;
      end else begin
         wr_gnt  <= w_gnt[0];
         rd_gnt  <= w_gnt[1];
         rd_data <= (w_gnt[1] && w_rd_ok) ? r_store[rd_id] : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_idx           <= 3'd0;
         r_best          <= 8'd0;
         r_best_idx      <= 3'd0;
         r_unique        <= 1'b0;
         r_best_scores   <= 16'd0;
         scan_busy       <= 1'b0;
         scan_done       <= 1'b0;
         winner_index    <= 4'd0;
         winner_l2_tens  <= 4'd0;
         winner_l2_units <= 4'd0;
         winner_l3_tens  <= 4'd0;
         winner_l3_units <= 4'd0;
      end else begin
         scan_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (scan_start) begin
                  r_state    <= S_SCAN;
                  r_idx      <= 3'd0;
                  r_best     <= 8'd0;
                  r_best_idx <= 3'd0;
                  r_unique   <= 1'b0;
                  scan_busy  <= 1'b1;
               end
            end
            S_SCAN: begin
               if (w_gnt[2]) begin
                  if (w_scan_total > r_best) begin
                     r_best        <= w_scan_total;
                     r_best_idx    <= r_idx;
                     r_unique      <= 1'b1;
                     r_best_scores <= w_scan_scores;
                  end else if (w_scan_total == r_best) begin
                     r_unique <= 1'b0;
                  end
                  if (r_idx == c_LAST_IDX) r_state <= S_RESOLVE;
                  else                     r_idx   <= r_idx + 3'd1;
               end
            end
            S_RESOLVE: begin
               // A tie or an all-zero table reports player 0 with zero scores.
               winner_index    <= r_unique ? {1'b0, r_best_idx} : 4'd0;
               winner_l2_tens  <= r_unique ? r_best_scores[15:12] : 4'd0;
               winner_l2_units <= r_unique ? r_best_scores[11:8]  : 4'd0;
               winner_l3_tens  <= r_unique ? r_best_scores[7:4]   : 4'd0;
               winner_l3_units <= r_unique ? r_best_scores[3:0]   : 4'd0;
               scan_done       <= 1'b1;
               r_state         <= S_DONE;
            end
            S_DONE: begin
               scan_busy <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: begin
               scan_busy <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_player_record_arbiter.sv
// tb_player_record_arbiter: directed checks of grants, masked writes, reads,
// the high-score scan and asynchronous reset of player_record_arbiter.
`default_nettype none

module tb_player_record_arbiter;

   logic        clk;
   logic        rst;
   logic        wr_req;
   logic [2:0]  wr_id;
   logic [18:0] wr_mask;
   logic [18:0] wr_data;
   logic        wr_gnt;
   logic        rd_req;
   logic [2:0]  rd_id;
   logic        rd_gnt;
   logic [18:0] rd_data;
   logic        scan_start;
   logic        scan_busy;
   logic        scan_done;
   logic [3:0]  winner_index;
   logic [3:0]  winner_l2_tens;
   logic [3:0]  winner_l2_units;
   logic [3:0]  winner_l3_tens;
   logic [3:0]  winner_l3_units;

   int n_cmp;
   int n_bad;
   logic [18:0] exp_rec [5];

   player_record_arbiter dut (
      .clk             (clk),
      .rst             (rst),
      .wr_req          (wr_req),
      .wr_id           (wr_id),
      .wr_mask         (wr_mask),
      .wr_data         (wr_data),
      .wr_gnt          (wr_gnt),
      .rd_req          (rd_req),
      .rd_id           (rd_id),
      .rd_gnt          (rd_gnt),
      .rd_data         (rd_data),
      .scan_start      (scan_start),
      .scan_busy       (scan_busy),
      .scan_done       (scan_done),
      .winner_index    (winner_index),
      .winner_l2_tens  (winner_l2_tens),
      .winner_l2_units (winner_l2_units),
      .winner_l3_tens  (winner_l3_tens),
      .winner_l3_units (winner_l3_units)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [18:0] mkrec(input int l2t, input int l2u, input int l3t, input int l3u);
      return {1'b1, 1'b1, 4'(l2t), 4'(l2u), 1'b0, 4'(l3t), 4'(l3u)};
   endfunction

   task automatic do_write(input logic [2:0] id, input logic [18:0] mask, input logic [18:0] data);
      int n;
      n = 0;
      wr_req = 1'b1; wr_id = id; wr_mask = mask; wr_data = data;
      do begin tick(); n++; end while (!wr_gnt && n < 20);
      wr_req = 1'b0;
      check_eq("wr_gnt_seen", {31'd0, wr_gnt}, 32'd1);
      tick();
      check_eq("wr_gnt_single", {31'd0, wr_gnt}, 32'd0);
      if (id < 3'd5) exp_rec[id] = (exp_rec[id] & ~mask) | (data & mask);
   endtask

   task automatic do_read(input logic [2:0] id, output logic [18:0] data);
      int n;
      n = 0;
      rd_req = 1'b1; rd_id = id;
      do begin tick(); n++; end while (!rd_gnt && n < 20);
      data = rd_data;
      rd_req = 1'b0;
      check_eq("rd_gnt_seen", {31'd0, rd_gnt}, 32'd1);
      tick();
      check_eq("rd_data_idle", {13'd0, rd_data}, 32'd0);
   endtask

   task automatic run_scan(output int done_at);
      done_at = 0;
      scan_start = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         tick();
         if (k == 1) begin
            scan_start = 1'b0;
            check_eq("scan_busy_start", {31'd0, scan_busy}, 32'd1);
         end
         if (scan_done && done_at == 0) done_at = k;
      end
      check_eq("scan_busy_end", {31'd0, scan_busy}, 32'd0);
   endtask

   initial begin
      logic [18:0] rdv;
      int done_at;
      int n_done;
      n_cmp = 0;
      n_bad = 0;
      for (int i = 0; i < 5; i++) exp_rec[i] = '0;

      // Both requests held from reset; a mask of 0 makes the write harmless.
      rst = 1'b1;
      wr_req = 1'b1; wr_id = 3'd0; wr_mask = '0; wr_data = '0;
      rd_req = 1'b1; rd_id = 3'd0;
      scan_start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_wr_gnt", {31'd0, wr_gnt}, 32'd0);
      check_eq("rst_rd_gnt", {31'd0, rd_gnt}, 32'd0);
      check_eq("rst_rd_data", {13'd0, rd_data}, 32'd0);
      check_eq("rst_busy", {31'd0, scan_busy}, 32'd0);
      check_eq("rst_done", {31'd0, scan_done}, 32'd0);
      check_eq("rst_winner", {28'd0, winner_index}, 32'd0);
      rst = 1'b0;
      tick();
      check_eq("contend_wr_first", {30'd0, wr_gnt, rd_gnt}, 32'b10);
      wr_req = 1'b0;
      tick();
      check_eq("contend_rd_second", {30'd0, wr_gnt, rd_gnt}, 32'b01);
      rd_req = 1'b0;
      tick();
      check_eq("contend_no_repeat1", {30'd0, wr_gnt, rd_gnt}, 32'b00);
      tick();
      check_eq("contend_no_repeat2", {30'd0, wr_gnt, rd_gnt}, 32'b00);

      do_write(3'd2, 19'h7FFFF, 19'h5A5A5);
      do_read(3'd2, rdv);
      check_eq("read_id2", {13'd0, rdv}, 32'h5A5A5);

      // Masked write touches only the low nibble of id 2.
      do_write(3'd2, 19'h0000F, 19'h7FFF3);
      do_read(3'd2, rdv);
      check_eq("read_id2_masked", {13'd0, rdv}, 32'h5A5A3);

      // Tie: ids 1 and 3 both total 99, others lower.
      do_write(3'd1, 19'h7FFFF, mkrec(5, 0, 4, 9));
      do_write(3'd2, 19'h7FFFF, 19'h00000);
      do_write(3'd3, 19'h7FFFF, mkrec(4, 5, 5, 4));
      do_write(3'd4, 19'h7FFFF, mkrec(1, 0, 1, 0));
      run_scan(done_at);
      check_eq("tie_done_cycle", done_at, 7);
      check_eq("tie_winner", {28'd0, winner_index}, 32'd0);
      check_eq("tie_fields", {16'd0, winner_l2_tens, winner_l2_units, winner_l3_tens, winner_l3_units}, 32'h0000);

      // Totals {0, 45, 120, 30, 119}.
      do_write(3'd1, 19'h7FFFF, mkrec(2, 0, 2, 5));
      do_write(3'd2, 19'h7FFFF, mkrec(6, 5, 5, 5));
      do_write(3'd3, 19'h7FFFF, mkrec(1, 0, 2, 0));
      do_write(3'd4, 19'h7FFFF, mkrec(6, 0, 5, 9));
      run_scan(done_at);
      check_eq("win_done_cycle", done_at, 7);
      check_eq("win_index", {28'd0, winner_index}, 32'd2);
      check_eq("win_fields", {16'd0, winner_l2_tens, winner_l2_units, winner_l3_tens, winner_l3_units}, 32'h6555);

      // Out-of-range id: granted, store untouched, read returns 0.
      do_write(3'd7, 19'h40000, 19'h7FFFF);
      do_read(3'd7, rdv);
      check_eq("read_id7", {13'd0, rdv}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         do_read(3'(i), rdv);
         check_eq("store_after_id7", {13'd0, rdv}, {13'd0, exp_rec[i]});
      end

      // Reset three cycles into a scan.
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      tick();
      tick();
      check_eq("midscan_busy", {31'd0, scan_busy}, 32'd1);
      rst = 1'b1;
      #1;
      check_eq("rst_async_busy", {31'd0, scan_busy}, 32'd0);
      check_eq("rst_async_winner", {28'd0, winner_index}, 32'd0);
      check_eq("rst_async_fields", {16'd0, winner_l2_tens, winner_l2_units, winner_l3_tens, winner_l3_units}, 32'h0000);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) exp_rec[i] = '0;
      n_done = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (scan_done) n_done++;
      end
      check_eq("rst_no_scan_done", n_done, 0);
      check_eq("rst_busy_after", {31'd0, scan_busy}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         do_read(3'(i), rdv);
         check_eq("store_after_rst", {13'd0, rdv}, {13'd0, exp_rec[i]});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/player_record_arbiter.md
PLAYER_RECORD_ARBITER -- requirements
Module: player_record_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; the ports are named clk and rst.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  clock
- rst  in  1  async active-high reset
- wr_req  in  1  write request, held until granted
- wr_id  in  3  target player (0-4)
- wr_mask  in  19  per-bit write enable
- wr_data  in  19  write data
- wr_gnt  out  1  write performed (1-cycle pulse)
- rd_req  in  1  read request, held until granted
- rd_id  in  3  target player
- rd_gnt  out  1  read performed (1-cycle pulse)
- rd_data  out  19  record, valid while rd_gnt=1
- scan_start  in  1  start high-score scan (pulse)
- scan_busy  out  1  scan in progress
- scan_done  out  1  scan result valid (1-cycle pulse)
- winner_index  out  4  winning player
- winner_l2_tens, winner_l2_units, winner_l3_tens, winner_l3_units  out  4 each  winner's BCD scores
REQ-003 Constants (name, default, meaning): NUM_PLAYERS, 5, record count; RECORD_W, 19, record width.

Function
REQ-004 The block SHALL hold 5 x 19-bit records: [18] L2 unlocked, [17] L3 unlocked, [16:13] L2 tens, [12:9] L2 units, [8] L3 done, [7:4] L3 tens, [3:0] L3 units.
REQ-005 Exactly one record access (write, read or scan read) SHALL occur per cycle, chosen by 3-way round-robin in the order wr -> rd -> scan; the pointer moves to the entry after the granted one.
REQ-006 A grant decided in cycle N SHALL perform the access at the edge ending cycle N and assert the gnt pulse in cycle N+1.
REQ-007 A requester whose gnt is high SHALL be ineligible that cycle, so a request dropped on gnt yields exactly one access.
REQ-008 A write SHALL update only the bits set in wr_mask. A wr_id >= 5 SHALL be granted with no store change.
REQ-009 A read SHALL present the pre-edge record on rd_data with rd_gnt. A rd_id >= 5 SHALL return 0. rd_data SHALL be 0 when rd_gnt=0.
REQ-010 Scan FSM states SHALL be IDLE, SCAN, RESOLVE and DONE:
- IDLE: scan_start=1 -> SCAN with idx=0, best=0, best_idx=0, unique=0.
- SCAN: one scan request per record; each granted read advances idx; the grant for idx 4 -> RESOLVE.
- RESOLVE -> DONE, updating the winner outputs.
- DONE: scan_done=1 for one cycle, then IDLE.
REQ-011 scan_busy SHALL be 1 in SCAN, RESOLVE and DONE. scan_start SHALL be ignored outside IDLE.
REQ-012 Each scanned record's total SHALL be computed in 8 bits as L3tens*10 + L3units + L2tens*10 + L2units (max 198):
- total > best: set best=total, best_idx=idx, unique=1, and latch the record.
- total == best: set unique=0.
REQ-013 RESOLVE SHALL set the winner outputs as follows:
- unique=1: winner_index=best_idx and the four score fields from the latched record.
- otherwise (tie or all zero): winner_index=0 and all four score fields 0.
Winner outputs SHALL hold until the next RESOLVE.
REQ-014 With no contention, scan_done SHALL assert 7 cycles after the scan_start cycle.
REQ-015 A write granted during a scan SHALL be seen by the scan only if it is granted before that record's scan read.

Reset
REQ-016 rst SHALL immediately clear the following, and a reset mid-scan SHALL abort with no scan_done:
- all records to 0;
- every output to 0;
- the round-robin pointer to wr;
- the FSM to IDLE.

Structure
REQ-017 A shared package player_record_pkg SHALL hold NUM_PLAYERS, RECORD_W, the record field positions and the scan state encoding.
REQ-018 The round-robin logic SHALL be a sub-module rr_arbiter3 (req[2:0], gnt[2:0], pointer state); the store, datapath and scan FSM stay in player_record_arbiter.

Verification
REQ-019 Directed scenarios the bench SHALL cover:
- Write id=2, mask=0x7FFFF, data=0x5A5A5 with drop on gnt -> one wr_gnt; a later read of id=2 returns 0x5A5A5.
- wr_req and rd_req both held from reset, both dropped on gnt -> wr_gnt then rd_gnt on consecutive cycles, no repeat grants.
- Records with totals {0, 45, 120, 30, 119} (id 2 = L2 65, L3 55), then scan_start -> scan_done at cycle 7, winner_index=2, fields 6/5/5/5.
- Records 1 and 3 both total 99 -> winner_index=0 and all fields 0.
- Write mask=0x40000 to id=7, then read id=7 -> gnt given, store unchanged, rd_data=0.
- rst asserted 3 cycles after scan_start -> scan_busy=0 at once, no scan_done, records read back 0.
